// File: rtl/decode_queue_if.sv
// -----------------------------------------------------------------------------
// common_pkg + decode_queue_if
//
// common_pkg holds the instruction/decode types shared by fetch, decode and
// issue: instruction_t, the encoding enum and the control_t record, plus the
// RV32 major opcodes the decoder recognises.
//
// decode_queue_if bundles both handshakes of the decode queue:
//   in_valid/in_ready/in_instr/in_pc        fetch -> queue
//   out_valid/out_ready/out_instr/out_pc,
//   out_control/out_illegal/out_fp          queue -> issue
// Modports:
//   master : the environment (fetch driver + issue consumer)
//   slave  : the decode queue itself
// -----------------------------------------------------------------------------
package common_pkg;

    typedef logic [31:0] instruction_t;

    // ENC_NONE must stay the all-zero encoding so that an illegal entry's
    // control record is simply '0.
    typedef enum logic [2:0] {
        ENC_NONE = 3'd0,
        R_TYPE   = 3'd1,
        I_TYPE   = 3'd2,
        S_TYPE   = 3'd3,
        B_TYPE   = 3'd4,
        U_TYPE   = 3'd5,
        J_TYPE   = 3'd6
    } enc_t;

    typedef struct packed {
        enc_t       encoding;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } control_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

interface decode_queue_if;
    import common_pkg::*;

    logic         in_valid;
    logic         in_ready;
    instruction_t in_instr;
    logic [31:0]  in_pc;

    logic         out_valid;
    logic         out_ready;
    instruction_t out_instr;
    logic [31:0]  out_pc;
    control_t     out_control;
    logic         out_illegal;
    logic         out_fp;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_control, out_illegal, out_fp
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_control, out_illegal, out_fp
    );
endinterface

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
//
// Decode stage between fetch and issue. Each accepted instruction is
// classified (encoding type, legality, FP flag) combinationally and written,
// together with its PC, into a DEPTH-entry FIFO that drains to issue.
// Illegal instructions are still queued and are counted in a saturating
// counter; optionally the queue stops accepting after an illegal one until
// flush.
//
// Parameters:
//   DEPTH            FIFO entries (power of two, >= 2)
//   CNT_W            width of illegal_count
//   STALL_ON_ILLEGAL 1: hold in_ready low after accepting an illegal entry
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   flush          drop every queued entry, clear the stall latch
//   bus            decode_queue_if.slave (fetch-side and issue-side handshakes)
//   occupancy      number of entries held
//   illegal_count  illegal instructions accepted since reset (saturating)
//
// Build option:
//   FPU_DECODE_EN  when defined, F-extension opcodes decode as legal and set
//                  out_fp; otherwise they are illegal and out_fp is always 0.
// -----------------------------------------------------------------------------
module decode_queue
    import common_pkg::*;
#(
    parameter int DEPTH            = 4,
    parameter int CNT_W            = 16,
    parameter int STALL_ON_ILLEGAL = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    decode_queue_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           illegal_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        instruction_t instr;
        logic [31:0]  pc;
        control_t     control;
        logic         illegal;
        logic         fp;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational decode of the offered instruction
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    enc_t       dec_enc;
    logic       dec_fp;
    logic       dec_illegal;
    entry_t     in_entry;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign funct7 = bus.in_instr[31:25];

`ifdef FPU_DECODE_EN
    logic [4:0] rs2;
    assign rs2 = bus.in_instr[24:20];
`endif

    always_comb begin
        dec_enc = ENC_NONE;
        dec_fp  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: dec_enc = U_TYPE;
            OPC_JAL:            dec_enc = J_TYPE;
            OPC_JALR:   if (funct3 == 3'b000) dec_enc = I_TYPE;
            // funct3 010/011 are unassigned branch conditions
            OPC_BRANCH: if (funct3 != 3'b010 && funct3 != 3'b011) dec_enc = B_TYPE;
            OPC_LOAD:   if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) dec_enc = I_TYPE;
            OPC_STORE:  if (funct3 <= 3'b010) dec_enc = S_TYPE;
            OPC_OP_IMM: begin
                // Shift-immediates carry a funct7 field that must be valid
                case (funct3)
                    3'b001:  if (funct7 == F7_BASE) dec_enc = I_TYPE;
                    3'b101:  if (funct7 == F7_BASE || funct7 == F7_ALT) dec_enc = I_TYPE;
                    default: dec_enc = I_TYPE;
                endcase
            end
            OPC_OP: begin
                if (funct7 == F7_BASE || funct7 == F7_MULDIV ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))
                    dec_enc = R_TYPE;
            end
`ifdef FPU_DECODE_EN
            OPC_LOAD_FP: begin
                if (funct3 == 3'b010) begin
                    dec_enc = I_TYPE;
                    dec_fp  = 1'b1;
                end
            end
            OPC_STORE_FP: begin
                if (funct3 == 3'b010) begin
                    dec_enc = S_TYPE;
                    dec_fp  = 1'b1;
                end
            end
            OPC_OP_FP: begin
                // Arithmetic ops use funct3 as rounding mode, so any value is accepted
                case (funct7)
                    7'b0000000, 7'b0000100,
                    7'b0001000, 7'b0001100: dec_enc = R_TYPE;
                    7'b0101100:             if (rs2 == 5'd0) dec_enc = R_TYPE;
                    7'b1010000:             if (funct3 <= 3'b010) dec_enc = R_TYPE;
                    7'b1110000, 7'b1111000: if (rs2 == 5'd0 && funct3 == 3'b000) dec_enc = R_TYPE;
                    default:                dec_enc = ENC_NONE;
                endcase
                dec_fp = (dec_enc != ENC_NONE);
            end
`endif
            default: dec_enc = ENC_NONE;
        endcase
    end

    assign dec_illegal = (dec_enc == ENC_NONE);

    always_comb begin
        in_entry                  = '0;
        in_entry.instr            = bus.in_instr;
        in_entry.pc               = bus.in_pc;
        in_entry.control.encoding = dec_enc;
        in_entry.illegal          = dec_illegal;
        in_entry.fp               = dec_fp;
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic             stall_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // Pointers carry one extra wrap bit: equal = empty, differing only in
    // the wrap bit = full.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // Flush blocks the push side outright so nothing offered in the flush
    // cycle is enqueued or counted.
    assign bus.in_ready  = rst_n && !full && !stall_reg && !flush;
    assign bus.out_valid = !empty;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            stall_reg  <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            stall_reg  <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (STALL_ON_ILLEGAL != 0 && push && dec_illegal) stall_reg <= 1'b1;
        end
    end

    // Flush does not touch the counter; push is already suppressed by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (push && dec_illegal && cnt_reg != '1) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign illegal_count = cnt_reg;
    assign occupancy     = wr_ptr_reg - rd_ptr_reg;

    // ------------------------------------------------------------------
    // Entry storage. No reset: stale slots are never visible because the
    // head is gated by out_valid, which reset clears.
    // ------------------------------------------------------------------
    entry_t mem_reg [DEPTH];
    entry_t head_entry;
    entry_t out_entry;

    always_ff @(posedge clk) begin
        if (push) mem_reg[wr_ptr_reg[AW-1:0]] <= in_entry;
    end

    assign head_entry = mem_reg[rd_ptr_reg[AW-1:0]];
    assign out_entry  = bus.out_valid ? head_entry : '0;

    assign bus.out_instr   = out_entry.instr;
    assign bus.out_pc      = out_entry.pc;
    assign bus.out_control = out_entry.control;
    assign bus.out_illegal = out_entry.illegal;
    assign bus.out_fp      = out_entry.fp;

endmodule

// File: tb/tb_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_queue
//
// Main instance (DEPTH=4, CNT_W=16, no stall): directed and random traffic
// checked by a scoreboard. The predictor pushes the expected decode of every
// accepted instruction (from a mask/match rule table) into exp_q; the monitor
// pops and compares whenever the head is presented.
// Second instance (CNT_W=2, STALL_ON_ILLEGAL=1): directed stall, flush and
// counter saturation checks.
// -----------------------------------------------------------------------------
module tb_decode_queue;
    import common_pkg::*;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             flush   = 1'b0;
    logic             s_flush = 1'b0;
    logic [2:0]       occupancy;
    logic [2:0]       s_occupancy;
    logic [CNT_W-1:0] illegal_count;
    logic [1:0]       s_illegal_count;

    always #5 clk = ~clk;

    decode_queue_if m_if ();
    decode_queue_if s_if ();

    decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W), .STALL_ON_ILLEGAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(m_if),
        .occupancy(occupancy), .illegal_count(illegal_count)
    );

    decode_queue #(.DEPTH(DEPTH), .CNT_W(2), .STALL_ON_ILLEGAL(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .bus(s_if),
        .occupancy(s_occupancy), .illegal_count(s_illegal_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference decoder: first-principles mask/match rule table
    // ------------------------------------------------------------------
    logic [31:0] tbl_mask[$];
    logic [31:0] tbl_match[$];
    enc_t        tbl_enc[$];
    logic        tbl_fp[$];

    function automatic void add_rule(input logic [31:0] m, input logic [31:0] v, input enc_t e, input logic f);
        tbl_mask.push_back(m);
        tbl_match.push_back(v);
        tbl_enc.push_back(e);
        tbl_fp.push_back(f);
    endfunction

    function automatic void build_table();
        int br[6] = '{0, 1, 4, 5, 6, 7};
        int ld[5] = '{0, 1, 2, 4, 5};
        int oi[6] = '{0, 2, 3, 4, 6, 7};
        add_rule(32'h0000007F, 32'h00000037, U_TYPE, 1'b0);
        add_rule(32'h0000007F, 32'h00000017, U_TYPE, 1'b0);
        add_rule(32'h0000007F, 32'h0000006F, J_TYPE, 1'b0);
        add_rule(32'h0000707F, 32'h00000067, I_TYPE, 1'b0);
        foreach (br[k]) add_rule(32'h0000707F, 32'h00000063 | (32'(br[k]) << 12), B_TYPE, 1'b0);
        foreach (ld[k]) add_rule(32'h0000707F, 32'h00000003 | (32'(ld[k]) << 12), I_TYPE, 1'b0);
        for (int k = 0; k < 3; k++) add_rule(32'h0000707F, 32'h00000023 | (32'(k) << 12), S_TYPE, 1'b0);
        foreach (oi[k]) add_rule(32'h0000707F, 32'h00000013 | (32'(oi[k]) << 12), I_TYPE, 1'b0);
        add_rule(32'hFE00707F, 32'h00001013, I_TYPE, 1'b0);   // SLLI
        add_rule(32'hFE00707F, 32'h00005013, I_TYPE, 1'b0);   // SRLI
        add_rule(32'hFE00707F, 32'h40005013, I_TYPE, 1'b0);   // SRAI
        add_rule(32'hFE00007F, 32'h00000033, R_TYPE, 1'b0);   // base ALU
        add_rule(32'hFE00007F, 32'h02000033, R_TYPE, 1'b0);   // M extension
        add_rule(32'hFE00707F, 32'h40000033, R_TYPE, 1'b0);   // SUB
        add_rule(32'hFE00707F, 32'h40005033, R_TYPE, 1'b0);   // SRA
`ifdef FPU_DECODE_EN
        add_rule(32'h0000707F, 32'h00002007, I_TYPE, 1'b1);   // FLW
        add_rule(32'h0000707F, 32'h00002027, S_TYPE, 1'b1);   // FSW
        for (int k = 0; k < 4; k++) add_rule(32'hFE00007F, 32'h00000053 | (32'(k * 4) << 25), R_TYPE, 1'b1);
        add_rule(32'hFFF0007F, 32'h00000053 | (32'h2C << 25), R_TYPE, 1'b1);
        for (int k = 0; k < 3; k++) add_rule(32'hFE00707F, 32'h00000053 | (32'h50 << 25) | (32'(k) << 12), R_TYPE, 1'b1);
        add_rule(32'hFFF0707F, 32'h00000053 | (32'h70 << 25), R_TYPE, 1'b1);
        add_rule(32'hFFF0707F, 32'h00000053 | (32'h78 << 25), R_TYPE, 1'b1);
`endif
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output enc_t e, output logic f);
        e = ENC_NONE;
        f = 1'b0;
        foreach (tbl_mask[k]) begin
            if ((ins & tbl_mask[k]) == tbl_match[k]) begin
                e = tbl_enc[k];
                f = tbl_fp[k];
            end
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opcs[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h07, 7'h27, 7'h53};
        logic [6:0]  f7s[8]   = '{7'h00, 7'h20, 7'h01, 7'h04, 7'h2C, 7'h50, 7'h70, 7'h78};
        case ($urandom_range(0, 9))
            0: ins = $urandom();
            1: ins = 32'hFFFF_FFFF;
            2: ins = 32'h0;
            default: begin
                ins = $urandom();
                ins[6:0] = opcs[$urandom_range(0, 11)];
                if ($urandom_range(0, 1) == 1) ins[31:25] = f7s[$urandom_range(0, 7)];
                if ($urandom_range(0, 2) == 0) ins[24:20] = 5'd0;
            end
        endcase
        return ins;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        enc_t        enc;
        logic        ill;
        logic        fp;
    } exp_t;

    exp_t exp_q[$];
    int   cnt_m      = 0;
    logic popped_now = 1'b0;
    logic chk_en     = 1'b0;
    logic done_s     = 1'b0;

    // Predictor: runs after the monitor in the same half cycle; decides the
    // fetch-side outcome of the coming edge and records expectations.
    always begin : predictor
        int   sz_before;
        logic exp_ready;
        enc_t e;
        logic f;
        exp_t item;
        @(negedge clk);
        #1;
        if (chk_en) begin
            sz_before = exp_q.size() + (popped_now ? 1 : 0);
            exp_ready = (sz_before < DEPTH) && !flush;
            check("in_ready", m_if.in_ready, exp_ready);
            if (flush) begin
                exp_q.delete();
            end else if (m_if.in_valid && exp_ready) begin
                ref_decode(m_if.in_instr, e, f);
                item.instr = m_if.in_instr;
                item.pc    = m_if.in_pc;
                item.enc   = e;
                item.ill   = (e == ENC_NONE);
                item.fp    = f;
                exp_q.push_back(item);
                if (item.ill && cnt_m != CNT_MAX) cnt_m++;
            end
        end
    end

    // Monitor: compares the presented head and pops on a drain.
    always @(negedge clk) begin : monitor
        exp_t     head;
        control_t ctl;
        if (chk_en) begin
            popped_now = 1'b0;
            check("occupancy", occupancy, exp_q.size());
            check("out_valid", m_if.out_valid, exp_q.size() != 0);
            check("illegal_count", illegal_count, cnt_m);
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                ctl = '0;
                ctl.encoding = head.enc;
                check("out_instr", m_if.out_instr, head.instr);
                check("out_pc", m_if.out_pc, head.pc);
                check("out_control", m_if.out_control, ctl);
                check("out_illegal", m_if.out_illegal, head.ill);
                check("out_fp", m_if.out_fp, head.fp);
                if (m_if.out_ready && !flush) begin
                    void'(exp_q.pop_front());
                    popped_now = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic drive(input logic v, input logic [31:0] ins, input logic r, input logic fl);
        @(posedge clk);
        #1;
        m_if.in_valid  = v;
        m_if.in_instr  = ins;
        m_if.in_pc     = pc_ctr;
        m_if.out_ready = r;
        flush          = fl;
        pc_ctr         = pc_ctr + 32'd4;
    endtask

    initial begin : main_stim
        logic r;
        build_table();
        m_if.in_valid  = 1'b0;
        m_if.in_instr  = '0;
        m_if.in_pc     = '0;
        m_if.out_ready = 1'b0;

        @(negedge clk);
        check("rst_in_ready", m_if.in_ready, 0);
        check("rst_out_valid", m_if.out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_illegal_count", illegal_count, 0);
        check("rst_out_instr", m_if.out_instr, 0);
        check("rst_out_pc", m_if.out_pc, 0);
        check("rst_out_control", m_if.out_control, 0);
        check("rst_out_illegal", m_if.out_illegal, 0);
        check("rst_out_fp", m_if.out_fp, 0);

        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // ADDI x1,x0,5 then the two illegal extremes
        drive(1'b1, 32'h0050_0093, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drive(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Six back-to-back offers into a stalled consumer, then drain
        for (int i = 0; i < 6; i++) drive(1'b1, 32'h0000_0093 | (32'(i + 1) << 20), 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);

        // FADD.S
        drive(1'b1, 32'h0020_8053, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic with alternating backpressure phases
        for (int i = 0; i < 1500; i++) begin
            if (((i / 100) % 3) == 0) r = ($urandom_range(0, 3) == 0);
            else                      r = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 3) != 0, rand_instr(), r, $urandom_range(0, 49) == 0);
        end

        // Occupancy 3, then flush concurrent with an offered illegal
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h0000_0013, 1'b0, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drive(1'b1, 32'h0000_0013, 1'b0, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 200 && !done_s; i++) @(posedge clk);
        check("stall_block_done", done_s, 1);

        // Asynchronous reset mid-stream, away from any clock edge
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("async_rst_out_valid", m_if.out_valid, 0);
        check("async_rst_occupancy", occupancy, 0);
        check("async_rst_illegal_count", illegal_count, 0);
        check("async_rst_in_ready", m_if.in_ready, 0);
        check("async_rst_s_in_ready", s_if.in_ready, 0);
        check("async_rst_s_illegal_count", s_illegal_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ------------------------------------------------------------------
    // Stall-on-illegal / saturation instance
    // ------------------------------------------------------------------
    task automatic drive_s(input logic v, input logic [31:0] ins, input logic r, input logic fl);
        @(posedge clk);
        #1;
        s_if.in_valid  = v;
        s_if.in_instr  = ins;
        s_if.in_pc     = 32'h0000_2000;
        s_if.out_ready = r;
        s_flush        = fl;
    endtask

    initial begin : stall_stim
        s_if.in_valid  = 1'b0;
        s_if.in_instr  = '0;
        s_if.in_pc     = '0;
        s_if.out_ready = 1'b0;

        @(negedge clk);
        check("s_rst_in_ready", s_if.in_ready, 0);
        check("s_rst_occupancy", s_occupancy, 0);
        check("s_rst_illegal_count", s_illegal_count, 0);

        for (int i = 0; i < 20 && !rst_n; i++) @(posedge clk);

        drive_s(1'b1, 32'h4000_1033, 1'b0, 1'b0);
        drive_s(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        @(negedge clk);
        check("s_stall_in_ready", s_if.in_ready, 0);
        check("s_stall_occupancy", s_occupancy, 1);
        check("s_stall_count", s_illegal_count, 1);
        check("s_head_illegal", s_if.out_illegal, 1);
        check("s_head_control", s_if.out_control, 0);
        check("s_head_instr", s_if.out_instr, 32'h4000_1033);

        repeat (3) drive_s(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        @(negedge clk);
        check("s_stall_hold_ready", s_if.in_ready, 0);
        check("s_stall_hold_occupancy", s_occupancy, 1);

        drive_s(1'b1, 32'h0050_0093, 1'b0, 1'b1);
        @(negedge clk);
        check("s_flush_in_ready", s_if.in_ready, 0);
        drive_s(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("s_after_flush_occupancy", s_occupancy, 0);
        check("s_after_flush_out_valid", s_if.out_valid, 0);
        check("s_after_flush_in_ready", s_if.in_ready, 1);
        check("s_after_flush_count", s_illegal_count, 1);

        for (int k = 0; k < 4; k++) begin
            drive_s(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
            drive_s(1'b0, 32'h0, 1'b0, 1'b1);
        end
        drive_s(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("s_saturated_count", s_illegal_count, 3);
        check("s_saturated_in_ready", s_if.in_ready, 1);

        drive_s(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        drive_s(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("s_legal_no_stall", s_if.in_ready, 1);
        check("s_legal_occupancy", s_occupancy, 1);
        check("s_legal_encoding", s_if.out_control.encoding, I_TYPE);
        check("s_legal_illegal_flag", s_if.out_illegal, 0);
        done_s = 1'b1;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage between fetch and issue. It takes a stream of 32-bit instructions over a valid/ready handshake and classifies each one: encoding type, legality, FP flag. The decoded records sit in a DEPTH-entry FIFO and drain to the issue stage over a second valid/ready handshake. It adds flush, a saturating illegal-instruction counter and an optional stall-on-illegal mode. Legality and encoding tables come from common_pkg types.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_W, 16: width of illegal_count.
- STALL_ON_ILLEGAL, 0: when 1, in_ready is held low after an illegal instruction is accepted, until flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  drop all queued entries; clear the stall latch.
- in_valid  in  1  fetch offers in_instr/in_pc.
- in_ready  out  1  queue accepts this cycle.
- in_instr  in  32  instruction_t.
- in_pc  in  32  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  issue consumes head.
- out_instr  out  32  head instruction.
- out_pc  out  32  head PC.
- out_control  out  control_t  head decode; only .encoding is populated, rest '0.
- out_illegal  out  1  head is not a legal instruction.
- out_fp  out  1  head is an F-extension instruction.
- occupancy  out  $clog2(DEPTH+1)  entries held.
- illegal_count  out  CNT_W  illegal instructions accepted since reset.

## Operation
- Decode is combinational on in_instr. The result is written into the FIFO tail on accept (in_valid && in_ready).
- Legal set:
  - LUI, AUIPC → U_TYPE.
  - JAL → J_TYPE.
  - JALR with funct3=000 → I_TYPE.
  - BRANCH with funct3 ∈ {000,001,100,101,110,111} → B_TYPE.
  - LOAD with funct3 ∈ {000,001,010,100,101} → I_TYPE.
  - STORE with funct3 ∈ {000,001,010} → S_TYPE.
  - OP-IMM → I_TYPE. SLLI requires funct7=0000000. SRLI/SRAI require funct7 ∈ {0000000,0100000}.
  - OP → R_TYPE:
    - funct7=0000000: all funct3.
    - funct7=0100000: only funct3 000/101.
    - funct7=0000001 (RV32M): all funct3.
- Any other opcode/funct combination is illegal. An illegal entry carries control='0, out_illegal=1, out_fp=0.
- Illegal entries are still enqueued, not dropped. On accept of an illegal entry, illegal_count increments, saturating at all-ones.
- STALL_ON_ILLEGAL=1: a stall latch sets on accept of an illegal entry and forces in_ready=0. Only flush or reset clears it. Entries already queued continue to drain.
- in_ready = !full && !stall. There is no same-cycle pass-through when full.
- A push and a pop in the same cycle leave occupancy unchanged.
- Flush:
  - Occupancy goes to 0 and out_valid is 0 next cycle.
  - Flush wins over a same-cycle push: the offered instruction is not accepted and not counted, and in_ready is forced 0 during flush.
  - illegal_count is not cleared by flush.
- Read and write pointers are log2(DEPTH)+1 bits and wrap naturally. Full and empty are distinguished by the MSB.

## Timing
- Latency: an instruction accepted in cycle N appears at the head with out_valid=1 in cycle N+1, when the queue was empty.
- out_* signals are registered FIFO outputs. They are stable while out_valid && !out_ready.
- Reset values:
  - in_ready=1 (0 while rst_n low).
  - out_valid=0, occupancy=0, illegal_count=0, stall latch=0.
  - out_instr/out_pc/out_control/out_illegal/out_fp='0.
- Asserting rst_n low mid-operation immediately empties the queue and clears counter and latch. No partial entry survives.
- Throughput: one accept and one drain per cycle sustained.

## Configuration
- FPU_DECODE_EN defined:
  - FLW (0000111, funct3=010) → I_TYPE.
  - FSW (0100111, funct3=010) → S_TYPE.
  - OP-FP (1010011) → R_TYPE, with funct7 0000000/0000100/0001000/0001100 (FADD/FSUB/FMUL/FDIV).
  - 0101100 with rs2=00000 (FSQRT).
  - 1010000 with funct3 ∈ {000,001,010} (FLE/FLT/FEQ).
  - 1110000 and 1111000 with rs2=00000, funct3=000 (FMV.X.W/FMV.W.X).
  - All of these set out_fp=1.
- FPU_DECODE_EN undefined: all of those opcodes are illegal, out_fp is tied 0 and no FP decode logic is synthesised.

## Test plan
- Reset, then push 0x00500093 (ADDI x1,x0,5) with out_ready=1 → next cycle out_valid=1, encoding=I_TYPE, out_illegal=0, illegal_count=0.
- Push 0xFFFFFFFF, then 0x00000000 → both enqueued with out_illegal=1, illegal_count=2. With CNT_W=2, five illegals leave illegal_count=3.
- DEPTH=4, out_ready=0, push 6 legal instructions back-to-back → exactly 4 accepted, occupancy=4, in_ready=0. Raise out_ready → FIFO order preserved across pointer wrap.
- Push 0x00208053 (FADD.S) → with FPU_DECODE_EN: R_TYPE, out_fp=1. Without: out_illegal=1, out_fp=0.
- STALL_ON_ILLEGAL=1: push 0x40001033 (illegal funct7 with funct3=001) → in_ready=0 next cycle and held. Pulse flush → occupancy=0, in_ready=1, counter still 1.
- Occupancy 3, assert flush concurrent with in_valid, then assert rst_n low mid-stream → flush cycle accepts nothing. Reset clears out_valid, occupancy and illegal_count asynchronously.
